vga_rect_fill: RTL and testbench

//  Rectangle-fill drawing engine directly upstream of the VGA framebuffer write port.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_clip.sv | 31 +++
 rtl/vga_rect_fill.sv | 149 ++++++++++++++
 tb/tb_vga_rect_fill.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, colour type and fill-engine state encoding.
package vga_pkg;

    localparam int HSIZE = 320;
    localparam int VSIZE = 240;
    localparam int H_W   = 9;
    localparam int V_W   = 8;

    typedef logic [11:0] rgb12_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/vga_clip.sv
// Combinational rectangle clipper: exclusive end corner limited to the screen,
// plus an empty flag for rectangles with no visible pixel.
module vga_clip
    import vga_pkg::*;
(
    input  logic [H_W-1:0] x0,
    input  logic [V_W-1:0] y0,
    input  logic [H_W-1:0] w,
    input  logic [V_W-1:0] h,
    output logic [H_W:0]   xe,
    output logic [V_W:0]   ye,
    output logic           empty
);

    localparam logic [H_W:0] XMAX = (H_W+1)'(HSIZE);
    localparam logic [V_W:0] YMAX = (V_W+1)'(VSIZE);

    logic [H_W:0] w_xsum;
    logic [V_W:0] w_ysum;

    // One extra bit keeps the sums exact before the clamp.
    assign w_xsum = {1'b0, x0} + {1'b0, w};
    assign w_ysum = {1'b0, y0} + {1'b0, h};

    assign xe = (w_xsum > XMAX) ? XMAX : w_xsum;
    assign ye = (w_ysum > YMAX) ? YMAX : w_ysum;

    assign empty = (w == '0) || (h == '0) ||
                   ({1'b0, x0} >= XMAX) || ({1'b0, y0} >= YMAX);

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: one command in, one clipped raster-order pixel write per cycle out.
// Optional write stall input wr_hold when VGA_FILL_STALL_EN is defined.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic           rclk,
    input  logic           rst,
`ifdef VGA_FILL_STALL_EN
    input  logic           wr_hold,
`endif
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [H_W-1:0] cmd_x0,
    input  logic [V_W-1:0] cmd_y0,
    input  logic [H_W-1:0] cmd_w,
    input  logic [V_W-1:0] cmd_h,
    input  logic [11:0]    cmd_color,
    output logic           busy,
    output logic           done,
    output logic           we,
    output logic [H_W-1:0] haddr,
    output logic [V_W-1:0] vaddr,
    output logic [11:0]    wdata
);

    fill_state_t    r_state;
    fill_state_t    w_next;

    logic [H_W-1:0] r_x0;
    logic [V_W-1:0] r_y0;
    logic [H_W-1:0] r_w;
    logic [V_W-1:0] r_h;
    rgb12_t         r_color;
    logic [H_W:0]   r_xe;
    logic [V_W:0]   r_ye;
    logic [H_W-1:0] r_x;
    logic [V_W-1:0] r_y;

    logic           r_we;
    logic           r_done;
    logic [H_W-1:0] r_haddr;
    logic [V_W-1:0] r_vaddr;
    rgb12_t         r_wdata;

    logic [H_W:0]   w_xe;
    logic [V_W:0]   w_ye;
    logic           w_empty;
    logic           w_hold;
    logic           w_accept;
    logic           w_draw;
    logic           w_row_end;
    logic           w_last;

`ifdef VGA_FILL_STALL_EN
    assign w_hold = wr_hold;
`else
    assign w_hold = 1'b0;
`endif

    vga_clip u_clip (
        .x0    (r_x0),
        .y0    (r_y0),
        .w     (r_w),
        .h     (r_h),
        .xe    (w_xe),
        .ye    (w_ye),
        .empty (w_empty)
    );

    // The done cycle still counts as busy so a new command waits one more cycle.
    assign busy      = (r_state != IDLE) || r_done;
    assign cmd_ready = ~busy;

    assign w_row_end = ({1'b0, r_x} == (r_xe - (H_W+1)'(1)));
    assign w_last    = w_row_end && ({1'b0, r_y} == (r_ye - (V_W+1)'(1)));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_draw   = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = cmd_valid && cmd_ready;
                if (w_accept) w_next = CLIP;
            end
            CLIP: w_next = w_empty ? DONE : DRAW;
            DRAW: begin
                if (!w_hold) begin
                    w_draw = 1'b1;
                    if (w_last) w_next = DONE;
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_haddr <= '0;
            r_vaddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= w_draw;
            r_done  <= (r_state == DONE);
            if (w_draw) begin
                r_haddr <= r_x;
                r_vaddr <= r_y;
                r_wdata <= r_color;
            end
        end
    end

    // Command fields, clip results and raster counters carry no reset; they are
    // always loaded before use.
    always_ff @(posedge rclk) begin
        if (w_accept) begin
            r_x0    <= cmd_x0;
            r_y0    <= cmd_y0;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
        end
        if (r_state == CLIP) begin
            r_xe <= w_xe;
            r_ye <= w_ye;
            r_x  <= r_x0;
            r_y  <= r_y0;
        end else if (w_draw) begin
            if (w_row_end) begin
                r_x <= r_x0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign we    = r_we;
    assign done  = r_done;
    assign haddr = r_haddr;
    assign vaddr = r_vaddr;
    assign wdata = r_wdata;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill; stall scenario built when VGA_FILL_STALL_EN is defined.
module tb_vga_rect_fill;

    logic        rclk = 1'b0;
    logic        rst  = 1'b1;
    logic        wr_hold = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x0 = '0;
    logic [7:0]  cmd_y0 = '0;
    logic [8:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic        busy, done, we;
    logic [8:0]  haddr;
    logic [7:0]  vaddr;
    logic [11:0] wdata;

    vga_rect_fill dut (
        .rclk      (rclk),
        .rst       (rst),
`ifdef VGA_FILL_STALL_EN
        .wr_hold   (wr_hold),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .we        (we),
        .haddr     (haddr),
        .vaddr     (vaddr),
        .wdata     (wdata)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        bit is_done;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   gap_en = 1'b1;
    bit   started = 1'b0;

    always @(posedge rclk) cyc = cyc + 1;

    // Monitor: every write or done pulse must match the head of the scoreboard.
    always @(negedge rclk) begin
        exp_t e;
        if (we === 1'b1 || done === 1'b1) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_output: got we=%0d done=%0d x=%0d y=%0d, need no output", we, done, haddr, vaddr);
            end else begin
                e = sb.pop_front();
                if (e.is_done) begin
                    if (!(done === 1'b1 && we === 1'b0)) begin
                        bad = bad + 1;
                        $display("FAIL done_event: got we=%0d done=%0d x=%0d y=%0d, need done=1 we=0", we, done, haddr, vaddr);
                    end
                end else if (!(we === 1'b1 && done === 1'b0 && haddr == 9'(e.x) && vaddr == 8'(e.y) && wdata == 12'(e.c))) begin
                    bad = bad + 1;
                    $display("FAIL pixel_write: got we=%0d done=%0d (%0d,%0d) c=%h, need we=1 (%0d,%0d) c=%h",
                             we, done, haddr, vaddr, wdata, e.x, e.y, e.c);
                end
            end
        end
        if (gap_en && started && we !== 1'b1 && done !== 1'b1) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL write_gap: got we=%0d inside a rectangle, need consecutive writes", we);
        end
        if (we === 1'b1) started = 1'b1;
        if (done === 1'b1 || cmd_ready === 1'b1) started = 1'b0;
    end

    task automatic check(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, need %0d", name, got, exp);
        end
    endtask

    task automatic push_wr(input int x, input int y, input int c);
        exp_t e;
        e.is_done = 1'b0; e.x = x; e.y = y; e.c = c;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.x = 0; e.y = 0; e.c = 0;
        sb.push_back(e);
    endtask

    // Reference raster walk of a clipped rectangle.
    task automatic push_rect(input int x0, input int y0, input int w, input int h, input int c);
        int xe, ye;
        xe = (x0 + w > 320) ? 320 : x0 + w;
        ye = (y0 + h > 240) ? 240 : y0 + h;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                push_wr(x, y, c);
        push_done();
    endtask

    // Returns at posedge+1 right after the accepting edge.
    task automatic send(input int x0, input int y0, input int w, input int h, input int c);
        int n = 0;
        @(posedge rclk); #1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge rclk); #1;
            n++;
        end
        check("ready_before_send", int'(cmd_ready === 1'b1), 1);
        cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 12'(c);
        cmd_valid = 1'b1;
        @(posedge rclk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lat);
        int n = 0;
        while (done !== 1'b1 && n < 90000) begin
            @(negedge rclk);
            n++;
        end
        if (done !== 1'b1) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL %s_timeout: got no done, need done pulse", name);
        end else begin
            check({name, "_latency"}, cyc - acc_cyc, lat);
            check({name, "_ready_in_done"}, int'(cmd_ready), 0);
            @(negedge rclk);
            check({name, "_ready_after"}, int'(cmd_ready), 1);
            check({name, "_sb_empty"}, sb.size(), 0);
        end
    endtask

    initial begin
        int dcount;
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(we), 0);
        check("rst_addr", int'({haddr, vaddr}), 0);
        check("rst_wdata", int'(wdata), 0);
        @(posedge rclk); #1;
        rst = 1'b0;

        // Small box: explicit expected writes and first-write latency.
        push_wr(10, 20, 'hF00); push_wr(11, 20, 'hF00); push_wr(12, 20, 'hF00);
        push_wr(10, 21, 'hF00); push_wr(11, 21, 'hF00); push_wr(12, 21, 'hF00);
        push_done();
        send(10, 20, 3, 2, 'hF00);
        check("box_busy", int'(busy), 1);
        @(negedge rclk); check("box_we_c0", int'(we), 0);
        @(negedge rclk); check("box_we_c1", int'(we), 0);
        @(negedge rclk); check("box_we_c2", int'(we), 1);
        wait_done("box", 8);

        // Corner clip.
        push_wr(318, 238, 'h0F0); push_wr(319, 238, 'h0F0);
        push_wr(318, 239, 'h0F0); push_wr(319, 239, 'h0F0);
        push_done();
        send(318, 238, 5, 5, 'h0F0);
        wait_done("corner", 6);

        // Empty command with w=0: cycle-exact done and ready return.
        push_done();
        send(40, 40, 0, 7, 'h555);
        @(negedge rclk); check("empty_done_c0", int'(done), 0);
        @(negedge rclk); check("empty_done_c1", int'(done), 0);
        @(negedge rclk); check("empty_done_c2", int'(done), 1);
        check("empty_busy_c2", int'(busy), 1);
        check("empty_we_c2", int'(we), 0);
        @(negedge rclk);
        check("empty_done_c3", int'(done), 0);
        check("empty_ready_c3", int'(cmd_ready), 1);

        // Empty command with x0 off screen.
        push_done();
        send(320, 10, 10, 10, 'h777);
        wait_done("offscreen", 2);

        // Command offered mid-draw is ignored.
        push_rect(0, 0, 8, 2, 'hABC);
        send(0, 0, 8, 2, 'hABC);
        repeat (5) @(posedge rclk);
        #1;
        cmd_x0 = 9'd100; cmd_y0 = 8'd100; cmd_w = 9'd3; cmd_h = 8'd3; cmd_color = 12'hFFF;
        cmd_valid = 1'b1;
        @(posedge rclk); #1;
        cmd_valid = 1'b0;
        wait_done("ignored_cmd", 18);
        repeat (6) @(negedge rclk);
        check("ignored_cmd_idle", int'(busy), 0);

        // Full-screen clear.
        push_rect(0, 0, 320, 240, 'h000);
        send(0, 0, 320, 240, 'h000);
        wait_done("full_screen", 2 + 76800);

        // Reset mid-draw: writes stop and no done follows.
        push_rect(0, 0, 50, 10, 'h123);
        send(0, 0, 50, 10, 'h123);
        repeat (30) @(posedge rclk);
        #1;
        rst = 1'b1;
        gap_en = 1'b0;
        @(posedge rclk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge rclk);
        check("midrst_we", int'(we), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ready", int'(cmd_ready), 1);
        check("midrst_busy", int'(busy), 0);
        dcount = 0;
        repeat (10) begin
            @(negedge rclk);
            if (done === 1'b1 || we === 1'b1) dcount++;
        end
        check("midrst_quiet", dcount, 0);
        gap_en = 1'b1;

`ifdef VGA_FILL_STALL_EN
        // Three-cycle hold after the second write of a 4-pixel row.
        gap_en = 1'b0;
        push_wr(5, 5, 'h00F); push_wr(6, 5, 'h00F); push_wr(7, 5, 'h00F); push_wr(8, 5, 'h00F);
        push_done();
        send(5, 5, 4, 1, 'h00F);
        @(posedge rclk);
        @(posedge rclk);
        @(posedge rclk); #1;
        wr_hold = 1'b1;
        repeat (3) @(posedge rclk);
        #1;
        wr_hold = 1'b0;
        wait_done("stall", 9);
        gap_en = 1'b1;
`endif

        repeat (3) @(negedge rclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
